e_stage_reg: RTL and testbench

Decode-to-execute pipeline register of the five-stage MIPS core. Every operand, control field and exception-tracking attribute that the execute stage consumes (ALU, multiply/divide/HILO unit, E-stage forwarding) comes from here. The block is the single point where stall bubbles and exception/interrupt flushes enter the execute stage. It is responsible for keeping the macro-PC and delay-slot information correct through bubbles, so that an interrupt taken while a bubble sits in E still records the right EPC.

---
 rtl/e_stage_reg.sv | 106 ++++++++++
 tb/tb_e_stage_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/e_stage_reg.sv
// Decode-to-execute pipeline register: one-cycle registered capture of D-stage fields into E.
// Stalls insert bubbles that keep the stalled PC/delay-slot flag for EPC; req flushes to the handler PC.
module e_stage_reg #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        stall,
  input  logic [31:0] d_pc,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_rd1,
  input  logic [31:0] d_rd2,
  input  logic [31:0] d_imm,
  input  logic [3:0]  d_aluop,
  input  logic [3:0]  d_hiloop,
  input  logic [4:0]  d_wa,
  input  logic [1:0]  d_tnew,
  input  logic        d_bd,
  input  logic [4:0]  d_exccode,
  output logic [31:0] e_pc,
  output logic [31:0] e_instr,
  output logic [31:0] e_rd1,
  output logic [31:0] e_rd2,
  output logic [31:0] e_imm,
  output logic [3:0]  e_aluop,
  output logic [3:0]  e_hiloop,
  output logic [4:0]  e_wa,
  output logic [1:0]  e_tnew,
  output logic        e_bd,
  output logic [4:0]  e_exccode,
  output logic        e_valid
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic [3:0]  hiloop;
    logic [4:0]  wa;
    logic [1:0]  tnew;
    logic        bd;
    logic [4:0]  exccode;
    logic        valid;
  } e_fields_t;

  e_fields_t r_e;
  e_fields_t w_nxt;
  logic      w_fault;

  assign w_fault = (d_exccode != 5'd0);

  always_comb begin
    w_nxt = '0;
    if (req) begin
      w_nxt.pc = HANDLER_PC;
    end else if (stall) begin
      // Bubble still carries the stalled instruction's PC and slot flag for EPC.
      w_nxt.pc = d_pc;
      w_nxt.bd = d_bd;
    end else begin
      w_nxt.pc      = d_pc;
      w_nxt.instr   = d_instr;
      w_nxt.rd1     = d_rd1;
      w_nxt.rd2     = d_rd2;
      w_nxt.imm     = d_imm;
      w_nxt.bd      = d_bd;
      w_nxt.exccode = d_exccode;
      w_nxt.valid   = 1'b1;
      // A faulting instruction must not start HILO work or write a GPR.
      if (!w_fault) begin
        w_nxt.aluop  = d_aluop;
        w_nxt.hiloop = d_hiloop;
        w_nxt.wa     = d_wa;
        w_nxt.tnew   = d_tnew;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e    <= '0;
      r_e.pc <= RESET_PC;
    end else begin
      r_e <= w_nxt;
    end
  end

  assign e_pc      = r_e.pc;
  assign e_instr   = r_e.instr;
  assign e_rd1     = r_e.rd1;
  assign e_rd2     = r_e.rd2;
  assign e_imm     = r_e.imm;
  assign e_aluop   = r_e.aluop;
  assign e_hiloop  = r_e.hiloop;
  assign e_wa      = r_e.wa;
  assign e_tnew    = r_e.tnew;
  assign e_bd      = r_e.bd;
  assign e_exccode = r_e.exccode;
  assign e_valid   = r_e.valid;

endmodule

// File: tb/tb_e_stage_reg.sv
// Self-checking bench for e_stage_reg: per-cycle model comparison plus directed literal checks.
module tb_e_stage_reg;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] RSTPC   = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc, instr, rd1, rd2, imm;
    logic [3:0]  aluop, hiloop;
    logic [4:0]  wa;
    logic [1:0]  tnew;
    logic        bd;
    logic [4:0]  exccode;
    logic        valid;
  } rec_t;

  logic clk = 1'b0;
  logic reset, req, stall;
  rec_t d;
  rec_t q;
  rec_t exp_q;
  logic exp_vld = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  e_stage_reg dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .d_pc(d.pc), .d_instr(d.instr), .d_rd1(d.rd1), .d_rd2(d.rd2), .d_imm(d.imm),
    .d_aluop(d.aluop), .d_hiloop(d.hiloop), .d_wa(d.wa), .d_tnew(d.tnew),
    .d_bd(d.bd), .d_exccode(d.exccode),
    .e_pc(q.pc), .e_instr(q.instr), .e_rd1(q.rd1), .e_rd2(q.rd2), .e_imm(q.imm),
    .e_aluop(q.aluop), .e_hiloop(q.hiloop), .e_wa(q.wa), .e_tnew(q.tnew),
    .e_bd(q.bd), .e_exccode(q.exccode), .e_valid(q.valid)
  );

  // What E must hold after an edge, stated directly from the priority rules.
  function automatic rec_t model(input logic rst, input logic rq, input logic st, input rec_t di);
    rec_t o;
    o = '0;
    if (rst) o.pc = RSTPC;
    else if (rq) o.pc = HANDLER;
    else if (st) begin
      o.pc = di.pc;
      o.bd = di.bd;
    end else begin
      o = di;
      o.valid = 1'b1;
      if (di.exccode != 0) begin
        o.aluop = 0; o.hiloop = 0; o.wa = 0; o.tnew = 0;
      end
    end
    return o;
  endfunction

  always @(posedge clk) begin
    exp_q   <= model(reset, req, stall, d);
    exp_vld <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_vld) begin
      chk("m_pc", q.pc, exp_q.pc);
      chk("m_instr", q.instr, exp_q.instr);
      chk("m_rd1", q.rd1, exp_q.rd1);
      chk("m_rd2", q.rd2, exp_q.rd2);
      chk("m_imm", q.imm, exp_q.imm);
      chk("m_aluop", 32'(q.aluop), 32'(exp_q.aluop));
      chk("m_hiloop", 32'(q.hiloop), 32'(exp_q.hiloop));
      chk("m_wa", 32'(q.wa), 32'(exp_q.wa));
      chk("m_tnew", 32'(q.tnew), 32'(exp_q.tnew));
      chk("m_bd", 32'(q.bd), 32'(exp_q.bd));
      chk("m_exccode", 32'(q.exccode), 32'(exp_q.exccode));
      chk("m_valid", 32'(q.valid), 32'(exp_q.valid));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] imm, input logic [3:0] aluop,
                       input logic [3:0] hiloop, input logic [4:0] wa, input logic [1:0] tnew,
                       input logic bd, input logic [4:0] exccode);
    d.pc = pc; d.instr = instr; d.rd1 = rd1; d.rd2 = rd2; d.imm = imm;
    d.aluop = aluop; d.hiloop = hiloop; d.wa = wa; d.tnew = tnew;
    d.bd = bd; d.exccode = exccode; d.valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; stall = 1'b0;
    set_d(32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_0001,
          4'hF, 4'h7, 5'd31, 2'd3, 1'b1, 5'd4);
    tick; tick;
    chk("rst_pc", q.pc, 32'h0000_3000);
    chk("rst_valid", 32'(q.valid), 0);
    chk("rst_hiloop", 32'(q.hiloop), 0);
    chk("rst_instr", q.instr, 0);

    // Normal capture of a mult.
    reset = 1'b0;
    set_d(32'h3010, 32'h0085_1018, 32'd7, 32'd6, 32'd0, 4'd0, 4'd1, 5'd0, 2'd0, 1'b0, 5'd0);
    tick;
    chk("nrm_pc", q.pc, 32'h3010);
    chk("nrm_instr", q.instr, 32'h0085_1018);
    chk("nrm_rd1", q.rd1, 32'd7);
    chk("nrm_rd2", q.rd2, 32'd6);
    chk("nrm_hiloop", 32'(q.hiloop), 1);
    chk("nrm_valid", 32'(q.valid), 1);

    // mfhi in a delay slot stalled for three cycles.
    set_d(32'h3014, 32'h0000_1010, 32'd0, 32'd0, 32'd0, 4'd2, 4'd5, 5'd2, 2'd1, 1'b1, 5'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stl_instr", q.instr, 0);
      chk("stl_hiloop", 32'(q.hiloop), 0);
      chk("stl_wa", 32'(q.wa), 0);
      chk("stl_pc", q.pc, 32'h3014);
      chk("stl_bd", 32'(q.bd), 1);
      chk("stl_valid", 32'(q.valid), 0);
    end
    stall = 1'b0;
    tick;
    chk("mfhi_hiloop", 32'(q.hiloop), 5);
    chk("mfhi_wa", 32'(q.wa), 2);
    chk("mfhi_tnew", 32'(q.tnew), 1);
    chk("mfhi_valid", 32'(q.valid), 1);

    // Flush wins over stall.
    set_d(32'h3020, 32'h2402_0001, 32'd1, 32'd2, 32'd1, 4'd1, 4'd0, 5'd2, 2'd1, 1'b1, 5'd8);
    req = 1'b1; stall = 1'b1;
    tick;
    chk("req_pc", q.pc, 32'h0000_4180);
    chk("req_bd", 32'(q.bd), 0);
    chk("req_valid", 32'(q.valid), 0);
    chk("req_exccode", 32'(q.exccode), 0);
    req = 1'b0; stall = 1'b0;

    // Faulting div (RI).
    set_d(32'h3024, 32'h0085_001A, 32'd100, 32'd3, 32'h44, 4'd3, 4'd3, 5'd5, 2'd2, 1'b0, 5'd10);
    tick;
    chk("flt_exccode", 32'(q.exccode), 10);
    chk("flt_hiloop", 32'(q.hiloop), 0);
    chk("flt_wa", 32'(q.wa), 0);
    chk("flt_pc", q.pc, 32'h3024);
    chk("flt_valid", 32'(q.valid), 1);
    chk("flt_rd1", q.rd1, 32'd100);
    chk("flt_imm", q.imm, 32'h44);

    // Reset arriving mid-stall.
    set_d(32'h3030, 32'h0000_0000, 32'd9, 32'd9, 32'd9, 4'd1, 4'd2, 5'd3, 2'd1, 1'b0, 5'd0);
    stall = 1'b1;
    tick;
    reset = 1'b1;
    tick;
    chk("rms_pc", q.pc, 32'h0000_3000);
    chk("rms_valid", 32'(q.valid), 0);
    reset = 1'b0;
    tick;
    chk("rms_bub_pc", q.pc, 32'h3030);
    chk("rms_bub_valid", 32'(q.valid), 0);
    chk("rms_bub_hiloop", 32'(q.hiloop), 0);
    stall = 1'b0;

    // Mixed control sequence; the per-cycle model covers every edge.
    for (int i = 0; i < 60; i++) begin
      set_d($urandom, $urandom, $urandom, $urandom, $urandom, 4'($urandom), 4'($urandom),
            5'($urandom), 2'($urandom), 1'($urandom), (($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0));
      reset = ($urandom_range(0, 15) == 0);
      req   = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      tick;
    end
    reset = 1'b0; req = 1'b0; stall = 1'b0;
    tick; tick;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
